// File: rtl/vec_mux_pipe_if.sv
// Request/response bundle between the register-file read ports and the vector mux pipe.
interface vec_mux_pipe_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec    [NUM_IN][DEPTH];
  logic [WIDTH-1:0] merge_vec [DEPTH];
  logic [SEL_W-1:0] sel;
  logic [DEPTH-1:0] lane_mask;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_vec   [DEPTH];
  logic             out_err;

  modport master (
    output in_valid, in_vec, merge_vec, sel, lane_mask, out_ready,
    input  in_ready, out_valid, out_vec, out_err
  );

  modport slave (
    input  in_valid, in_vec, merge_vec, sel, lane_mask, out_ready,
    output in_ready, out_valid, out_vec, out_err
  );
endinterface

// File: rtl/vec_mux_pipe.sv
// N-input vector mux with per-lane merge masking, registered output and a
// one-entry skid buffer so in_ready never depends combinationally on out_ready.
module vec_mux_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NUM_IN = 4
) (
  input logic           clk,
  input logic           rst,
  vec_mux_pipe_if.slave bus
);
  localparam int unsigned SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [WIDTH-1:0] new_vec_c  [DEPTH];
  logic             new_err_c;
  logic [WIDTH-1:0] out_vec_q  [DEPTH];
  logic             out_err_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] skid_vec_q [DEPTH];
  logic             skid_err_q;
  logic             skid_valid_q;
  logic             accept_c;
  logic             emit_c;

  assign accept_c = bus.in_valid & ~skid_valid_q;
  assign emit_c   = out_valid_q & bus.out_ready;

  // Select source lanes, merge masked-off lanes, flag an out-of-range select
  always_comb begin
    new_err_c = 1'b1;
    for (int unsigned s = 0; s < NUM_IN; s++) begin
      if (bus.sel == SEL_W'(s)) new_err_c = 1'b0;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      new_vec_c[i] = bus.merge_vec[i];
      if (bus.lane_mask[i]) begin
        new_vec_c[i] = '0;
        for (int unsigned s = 0; s < NUM_IN; s++) begin
          if (bus.sel == SEL_W'(s)) new_vec_c[i] = bus.in_vec[s][i];
        end
      end
    end
  end

  // Main register plus skid entry; skid drains into main before new data is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vec_q    <= '{default: '0};
      out_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_vec_q   <= '{default: '0};
      skid_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q) begin
      if (emit_c) begin
        out_vec_q    <= skid_vec_q;
        out_err_q    <= skid_err_q;
        skid_valid_q <= 1'b0;
      end
    end else if (!out_valid_q || emit_c) begin
      if (accept_c) begin
        out_vec_q   <= new_vec_c;
        out_err_q   <= new_err_c;
        out_valid_q <= 1'b1;
      end else if (emit_c) begin
        out_valid_q <= 1'b0;
      end
    end else if (accept_c) begin
      skid_vec_q   <= new_vec_c;
      skid_err_q   <= new_err_c;
      skid_valid_q <= 1'b1;
    end
  end

  // Drive interface outputs straight from state
  assign bus.in_ready  = ~skid_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_vec   = out_vec_q;
endmodule

// File: tb/tb_vec_mux_pipe.sv
// Directed and scoreboarded checks of vec_mux_pipe (NUM_IN=4 main, NUM_IN=3 for the error flag).
module tb_vec_mux_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vec_mux_pipe_if #(.WIDTH(32), .DEPTH(4), .NUM_IN(4)) bus4 ();
  vec_mux_pipe_if #(.WIDTH(32), .DEPTH(4), .NUM_IN(3)) bus3 ();

  vec_mux_pipe #(.WIDTH(32), .DEPTH(4), .NUM_IN(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  vec_mux_pipe #(.WIDTH(32), .DEPTH(4), .NUM_IN(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [128:0] sb_q [$];
  logic         sb_on     = 1'b0;
  logic         rand_rdy  = 1'b0;
  logic         stall_prev = 1'b0;
  logic [128:0] held;
  int           emits = 0;
  int           first_emit = 0;
  int           last_emit = 0;

  task automatic check(input string tag, input logic [128:0] got, input logic [128:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [128:0] pack4();
    return {bus4.out_err, bus4.out_vec[3], bus4.out_vec[2], bus4.out_vec[1], bus4.out_vec[0]};
  endfunction

  function automatic logic [128:0] pack3();
    return {bus3.out_err, bus3.out_vec[3], bus3.out_vec[2], bus3.out_vec[1], bus3.out_vec[0]};
  endfunction

  // Reference lane function for the 4-source instance, from bench-driven inputs
  function automatic logic [128:0] model4();
    logic [31:0] l [4];
    for (int i = 0; i < 4; i++)
      l[i] = bus4.lane_mask[i] ? bus4.in_vec[int'(bus4.sel)][i] : bus4.merge_vec[i];
    return {1'b0, l[3], l[2], l[1], l[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, wait (bounded) for acceptance, record expected result
  task automatic send(input logic [1:0] s, input logic [3:0] m);
    int w;
    bus4.sel       = s;
    bus4.lane_mask = m;
    bus4.in_valid  = 1'b1;
    w = 0;
    @(negedge clk);
    while (!bus4.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check("send_timeout", 1'b0, 1'b1);
    else sb_q.push_back(model4());
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
  endtask

  task automatic set_src_pattern();
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 4; i++) begin
        bus4.in_vec[s][i] = 32'(16 * s + i);
        if (s < 3) bus3.in_vec[s][i] = 32'(16 * s + i);
      end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      bus4.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard and stall-stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (sb_on) begin
      if (stall_prev && bus4.out_valid) check("stable", pack4(), held);
      if (bus4.out_valid && bus4.out_ready) begin
        if (sb_q.size() == 0) check("sb_underflow", 1'b1, 1'b0);
        else check("sb", pack4(), sb_q.pop_front());
        if (emits == 0) first_emit = cyc;
        last_emit = cyc;
        emits++;
      end
      stall_prev = bus4.out_valid && !bus4.out_ready;
      held = pack4();
    end
  end

  initial begin
    int w;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b1; bus4.sel = '0; bus4.lane_mask = '0;
    bus3.in_valid = 1'b0; bus3.out_ready = 1'b1; bus3.sel = '0; bus3.lane_mask = '0;
    for (int i = 0; i < 4; i++) begin
      bus4.merge_vec[i] = '0;
      bus3.merge_vec[i] = '0;
    end
    set_src_pattern();

    // Reset state
    tick();
    check("rst_out_valid", bus4.out_valid, 1'b0);
    check("rst_out_vec", pack4(), '0);
    check("rst_in_ready", bus4.in_ready, 1'b1);
    check("rst_in_ready3", bus3.in_ready, 1'b1);
    rst = 1'b0;

    // Basic select
    send(2'd2, 4'b1111);
    check("basic_valid", bus4.out_valid, 1'b1);
    check("basic_vec", pack4(), {1'b0, 32'h23, 32'h22, 32'h21, 32'h20});
    tick();
    check("basic_drain", bus4.out_valid, 1'b0);

    // Merge masking
    bus4.merge_vec[0] = 32'hAA; bus4.merge_vec[1] = 32'hBB;
    bus4.merge_vec[2] = 32'hCC; bus4.merge_vec[3] = 32'hDD;
    send(2'd1, 4'b0101);
    check("mask_vec", pack4(), {1'b0, 32'hDD, 32'h12, 32'hBB, 32'h10});
    tick();

    // Back-pressure into the skid entry
    bus4.out_ready = 1'b0;
    send(2'd0, 4'b1111);
    check("bp_in_ready1", bus4.in_ready, 1'b1);
    send(2'd3, 4'b1111);
    check("bp_in_ready2", bus4.in_ready, 1'b0);
    check("bp_main", pack4(), {1'b0, 32'h03, 32'h02, 32'h01, 32'h00});
    tick();
    check("bp_hold", pack4(), {1'b0, 32'h03, 32'h02, 32'h01, 32'h00});
    bus4.out_ready = 1'b1;
    tick();
    check("bp_skid_out", pack4(), {1'b0, 32'h33, 32'h32, 32'h31, 32'h30});
    check("bp_valid", bus4.out_valid, 1'b1);
    check("bp_in_ready3", bus4.in_ready, 1'b1);
    tick();
    check("bp_empty", bus4.out_valid, 1'b0);

    // Streaming: 16 back-to-back with ready held high
    sb_q.delete();
    emits = 0;
    stall_prev = 1'b0;
    sb_on = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus4.merge_vec[k % 4] = 32'(32'h100 + k);
      send(2'(k % 4), 4'(k * 5 + 3));
    end
    tick();
    tick();
    check("stream_count", emits, 16);
    check("stream_consec", last_emit - first_emit, 15);

    // Random ready with random payloads
    rand_rdy = 1'b1;
    for (int k = 0; k < 200; k++) begin
      for (int s = 0; s < 4; s++)
        for (int i = 0; i < 4; i++) bus4.in_vec[s][i] = $urandom;
      for (int i = 0; i < 4; i++) bus4.merge_vec[i] = $urandom;
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) tick();
    end
    w = 0;
    while (sb_q.size() != 0 && w < 500) begin
      tick();
      w++;
    end
    check("rand_drained", 32'(sb_q.size()), 32'd0);
    rand_rdy = 1'b0;
    tick();
    bus4.out_ready = 1'b1;
    tick();
    sb_on = 1'b0;
    set_src_pattern();

    // Out-of-range select on the 3-source instance
    for (int i = 0; i < 4; i++) bus3.merge_vec[i] = 32'h55;
    bus3.sel = 2'd3; bus3.lane_mask = 4'b0011; bus3.in_valid = 1'b1;
    tick();
    bus3.in_valid = 1'b0;
    check("err_vec", pack3(), {1'b1, 32'h55, 32'h55, 32'h00, 32'h00});
    bus3.sel = 2'd2; bus3.lane_mask = 4'b1111; bus3.in_valid = 1'b1;
    tick();
    bus3.in_valid = 1'b0;
    check("noerr_vec", pack3(), {1'b0, 32'h23, 32'h22, 32'h21, 32'h20});

    // Fill main and skid, then reset mid-cycle
    bus4.out_ready = 1'b0;
    send(2'd0, 4'b1111);
    send(2'd2, 4'b1111);
    check("fill_in_ready", bus4.in_ready, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_valid", bus4.out_valid, 1'b0);
    check("mid_rst_in_ready", bus4.in_ready, 1'b1);
    check("mid_rst_vec", pack4(), '0);
    tick();
    rst = 1'b0;
    bus4.out_ready = 1'b1;
    send(2'd1, 4'b1111);
    check("post_rst_first", pack4(), {1'b0, 32'h13, 32'h12, 32'h11, 32'h10});
    check("post_rst_valid", bus4.out_valid, 1'b1);
    tick();
    check("post_rst_empty", bus4.out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
